// File: rtl/wb_pkg.sv
// Shared definitions for the RV32 write-back stage.
//   - write-back source select encodings (wb_sel_e)
//   - load funct3 encodings
//   - queue entry layout (wb_entry_t) and the write-enable qualifier
package wb_pkg;

    localparam int WB_XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_NONE = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic               we;
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

    // An entry only writes when the instruction asks for it, the target is
    // not x0, and there is an actual result source.
    function automatic logic entry_write_enable(input logic       reg_write,
                                                input logic [4:0] rd,
                                                input logic [1:0] wb_sel);
        return reg_write && (rd != 5'd0) && (wb_sel != WB_NONE);
    endfunction

endpackage

// File: rtl/writeback_unit_load_extend.sv
// Load data alignment and extension (purely combinational).
// Ports:
//   mem_data  - raw aligned load word
//   funct3    - load size / sign select
//   addr_lo   - load address bits [1:0], picks the byte / half lane
//   ext_data  - extended result; unknown funct3 values pass the full word
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mem_data,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] ext_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection: byte by addr_lo, half by addr_lo[1].
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'b00:   byte_s = mem_data[7:0];
            2'b01:   byte_s = mem_data[15:8];
            2'b10:   byte_s = mem_data[23:16];
            2'b11:   byte_s = mem_data[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = mem_data[31:16];
        end else begin
            half_s = mem_data[15:0];
        end
    end

    // Sign/zero extension by load type.
    always_comb begin
        ext_data = mem_data;
        case (funct3)
            F3_LB:   ext_data = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_LH:   ext_data = {{(XLEN-16){half_s[15]}}, half_s};
            F3_LW:   ext_data = mem_data;
            F3_LBU:  ext_data = {{(XLEN-8){1'b0}}, byte_s};
            F3_LHU:  ext_data = {{(XLEN-16){1'b0}}, half_s};
            default: ext_data = mem_data;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// RV32 write-back stage: writer side of the register-file write port.
// Retiring results arrive on a valid/ready handshake, the final write value
// is formed at push time, and entries drain in order through a small ring
// into registered RegWrite/Rd/Write_data.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   in_valid / in_ready      - push handshake (in_ready from registered count)
//   in_reg_write, in_rd,
//   in_wb_sel, in_alu_result,
//   in_mem_data, in_pc,
//   in_funct3, in_addr_lo    - retiring instruction fields
//   wb_stall                 - register-file port busy, holds the queue
//   chk_rs1/2, hazard_rs1/2  - decode pending-write lookup (combinational)
//   RegWrite, Rd, Write_data - register-file write port (registered)
//   retire_count             - number of popped entries, wrapping
module writeback_unit
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_reg_write,
    input  logic [4:0]       in_rd,
    input  logic [1:0]       in_wb_sel,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic [XLEN-1:0]  in_mem_data,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic             wb_stall,
    input  logic [4:0]       chk_rs1,
    input  logic [4:0]       chk_rs2,
    output logic             hazard_rs1,
    output logic             hazard_rs2,
    output logic             RegWrite,
    output logic [4:0]       Rd,
    output logic [XLEN-1:0]  Write_data,
    output logic [CNT_W-1:0] retire_count
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_Q_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_Q_W-1:0] FULL_CNT = CNT_Q_W'(DEPTH);

    // Ring storage; valid bits make the hazard lookup independent of pointers.
    logic [XLEN-1:0]    data_q_r [DEPTH];
    logic [4:0]         rd_q_r   [DEPTH];
    logic [DEPTH-1:0]   we_q_r;
    logic [DEPTH-1:0]   valid_q_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_Q_W-1:0] count_r;

    logic            push_s;
    logic            pop_s;
    logic            new_we_s;
    logic [XLEN-1:0] new_data_s;
    logic [XLEN-1:0] load_data_s;
    logic            haz1_s;
    logic            haz2_s;

    // Ring pointers wrap at DEPTH, which need not fill the pointer width.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .mem_data (in_mem_data),
        .funct3   (in_funct3),
        .addr_lo  (in_addr_lo),
        .ext_data (load_data_s)
    );

    // Ready depends only on the registered occupancy, never on wb_stall.
    assign in_ready = (count_r != FULL_CNT);
    assign push_s   = in_valid && in_ready;
    assign pop_s    = (count_r != {CNT_Q_W{1'b0}}) && !wb_stall;
    assign new_we_s = entry_write_enable(in_reg_write, in_rd, in_wb_sel);

    // Final write value is resolved at push so the drain path is a plain move.
    always_comb begin
        new_data_s = {XLEN{1'b0}};
        case (wb_sel_e'(in_wb_sel))
            WB_ALU:  new_data_s = in_alu_result;
            WB_MEM:  new_data_s = load_data_s;
            WB_PC4:  new_data_s = in_pc + XLEN'(32'd4);
            WB_NONE: new_data_s = {XLEN{1'b0}};
            default: new_data_s = {XLEN{1'b0}};
        endcase
    end

    // Payload storage; contents are qualified by valid_q_r, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_q_r[wr_ptr_r] <= new_data_s;
            rd_q_r[wr_ptr_r]   <= in_rd;
        end
    end

    // Ring control: pointers, occupancy, per-slot valid and write-enable.
    // A push and a pop never target the same slot (push needs not-full,
    // pop needs not-empty), so the slot updates below cannot collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {CNT_Q_W{1'b0}};
            valid_q_r <= {DEPTH{1'b0}};
            we_q_r    <= {DEPTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r            <= next_ptr(wr_ptr_r);
                valid_q_r[wr_ptr_r] <= 1'b1;
                we_q_r[wr_ptr_r]    <= new_we_s;
            end
            if (pop_s) begin
                rd_ptr_r            <= next_ptr(rd_ptr_r);
                valid_q_r[rd_ptr_r] <= 1'b0;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_Q_W'(1);
                2'b01:   count_r <= count_r - CNT_Q_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Register-file port: a pop loads the head, otherwise RegWrite drops and
    // Rd/Write_data keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite     <= 1'b0;
            Rd           <= 5'd0;
            Write_data   <= {XLEN{1'b0}};
            retire_count <= {CNT_W{1'b0}};
        end else if (pop_s) begin
            RegWrite     <= we_q_r[rd_ptr_r];
            Rd           <= rd_q_r[rd_ptr_r];
            Write_data   <= data_q_r[rd_ptr_r];
            retire_count <= retire_count + CNT_W'(1);
        end else begin
            RegWrite     <= 1'b0;
        end
    end

    // Pending-write lookup: any queued writing entry or the write in flight.
    always_comb begin
        haz1_s = RegWrite && (Rd == chk_rs1);
        haz2_s = RegWrite && (Rd == chk_rs2);
        for (int i = 0; i < DEPTH; i++) begin
            haz1_s = haz1_s | (valid_q_r[i] && we_q_r[i] && (rd_q_r[i] == chk_rs1));
            haz2_s = haz2_s | (valid_q_r[i] && we_q_r[i] && (rd_q_r[i] == chk_rs2));
        end
    end

    assign hazard_rs1 = (chk_rs1 != 5'd0) && haz1_s;
    assign hazard_rs2 = (chk_rs2 != 5'd0) && haz2_s;

endmodule
